cas_key_loader: RTL and testbench

Serial key-delivery block for CAS-Lock-protected logic: it receives a secret key one bit per handshake, checks it with an even-parity bit, and drives the parallel key bus (`key_out`) that feeds the locked netlist's `keyinput_*` pins. The key bus stays all-zero until a complete, parity-correct key has been accepted, so the locked core stays in its corrupted mode during load and on error. It sits between the on-chip key store (tamper-proof memory or a test loader) and the locked combinational core.

---
 rtl/cas_key_loader.sv | 132 +++++++++++++
 tb/tb_cas_key_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cas_key_loader.sv
// Serial key loader for a CAS-Lock protected core: shifts in a key MSB first,
// checks even parity and exposes the key only once a whole, valid key is held.
module cas_key_loader #(
    parameter int KEY_WIDTH = 64,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    output logic                 bit_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_LOADED = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_WIDTH - 1);

    logic [2:0]           state, state_n;
    logic [KEY_WIDTH-1:0] sr, sr_n;
    logic [KEY_WIDTH-1:0] key_q, key_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 par, par_n;
    logic                 xfer;

    assign xfer = bit_valid & bit_ready;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        par_n   = par;
        key_n   = key_q;
        if (clear) begin
            state_n = S_IDLE;
            sr_n    = '0;
            cnt_n   = '0;
            par_n   = 1'b0;
            key_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state_n = S_SHIFT;
                end
                S_SHIFT: begin
                    if (xfer) begin
                        sr_n  = {sr[KEY_WIDTH-2:0], bit_data};
                        par_n = par ^ bit_data;
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST) state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (xfer) begin
                        // the parity bit never enters sr; it only closes the check
                        if ((par ^ bit_data) == 1'b0) begin
                            state_n = S_LOADED;
                            key_n   = sr;
                        end else begin
                            state_n = S_ERROR;
                        end
                        sr_n  = '0;
                        cnt_n = '0;
                        par_n = 1'b0;
                    end
                end
                S_LOADED: begin
                    state_n = S_LOADED;
                end
                S_ERROR: begin
                    if (start) begin
                        state_n = S_SHIFT;
                        sr_n    = '0;
                        cnt_n   = '0;
                        par_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    sr_n    = '0;
                    cnt_n   = '0;
                    par_n   = 1'b0;
                    key_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            key_q <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            par   <= par_n;
            key_q <= key_n;
        end
    end

    // status flags are flops loaded from the next state, so none of them
    // has a combinational path from the bit handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            bit_ready <= (state_n == S_SHIFT) || (state_n == S_PARITY);
            busy      <= (state_n == S_SHIFT) || (state_n == S_PARITY);
            key_valid <= (state_n == S_LOADED);
            error     <= (state_n == S_ERROR);
        end
    end

    assign key_out = key_q & {KEY_WIDTH{key_valid}};

endmodule

// File: tb/tb_cas_key_loader.sv
// Randomised and directed bench for cas_key_loader, checked against a
// bit-queue reference model of the key load protocol.
module tb_cas_key_loader;

    localparam int KW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_data = 1'b0;
    logic          bit_ready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          error;

    int checks = 0;
    int errors = 0;
    int edges = 0;
    int kv_edge = -1;

    always #5 clk = ~clk;

    cas_key_loader #(.KEY_WIDTH(KW), .CNT_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .clear(clear),
        .bit_valid(bit_valid),
        .bit_data(bit_data),
        .bit_ready(bit_ready),
        .key_out(key_out),
        .key_valid(key_valid),
        .busy(busy),
        .error(error)
    );

    // model modes: 0 idle, 1 collecting bits, 2 key held, 3 parity failure
    int            m_mode = 0;
    bit            m_bits[$];
    logic [KW-1:0] m_key = '0;

    function automatic void m_reset();
        m_mode = 0;
        m_bits.delete();
        m_key = '0;
    endfunction

    function automatic void m_step(bit st, bit cl, bit v, bit d);
        logic [KW-1:0] k;
        k = '0;
        if (cl) begin
            m_reset();
            return;
        end
        case (m_mode)
            0: if (st) begin m_mode = 1; m_bits.delete(); end
            1: if (v) begin
                if (m_bits.size() < KW) begin
                    m_bits.push_back(d);
                end else begin
                    foreach (m_bits[i]) k = k * 2 + KW'(m_bits[i]);
                    if ((($countones(k) + int'(d)) % 2) == 0) begin
                        m_mode = 2;
                        m_key = k;
                    end else begin
                        m_mode = 3;
                    end
                    m_bits.delete();
                end
            end
            3: if (st) begin m_mode = 1; m_bits.delete(); end
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [KW-1:0] got,
                       input logic [KW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("key_out", key_out, (m_mode == 2) ? m_key : '0);
        chk("key_valid", KW'(key_valid), KW'(m_mode == 2));
        chk("busy", KW'(busy), KW'(m_mode == 1));
        chk("bit_ready", KW'(bit_ready), KW'(m_mode == 1));
        chk("error", KW'(error), KW'(m_mode == 3));
    endtask

    task automatic cyc(input bit st, input bit cl, input bit v, input bit d);
        start = st;
        clear = cl;
        bit_valid = v;
        bit_data = d;
        @(posedge clk);
        m_step(st, cl, v, d);
        edges++;
        #1;
        if (key_valid === 1'b1 && kv_edge < 0) kv_edge = edges;
        chk_all();
        start = 1'b0;
        clear = 1'b0;
        bit_valid = 1'b0;
    endtask

    // sends key MSB first then parity; optional start pulse or abort by index
    task automatic send_key(input logic [KW-1:0] k, input bit p,
                            input int maxgap, input int start_at,
                            input int clear_at);
        for (int i = KW - 1; i >= -1; i--) begin
            int idx;
            bit d;
            idx = KW - 1 - i;
            if (clear_at == idx) begin
                cyc(0, 1, 0, 0);
                return;
            end
            repeat ($urandom_range(maxgap, 0))
                cyc(0, 0, 0, 1'($urandom_range(1, 0)));
            d = (i >= 0) ? k[i] : p;
            cyc(start_at == idx, 0, 1, d);
        end
    endtask

    initial begin
        int e0;
        m_reset();
        #1;
        chk("rst_key_out", key_out, '0);
        chk("rst_key_valid", KW'(key_valid), '0);
        chk("rst_busy", KW'(busy), '0);
        chk("rst_bit_ready", KW'(bit_ready), '0);
        chk("rst_error", KW'(error), '0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        // full load at one bit per cycle, latency measured from the start edge
        kv_edge = -1;
        cyc(1, 0, 0, 0);
        e0 = edges;
        send_key(64'hA5A5_0F0F_1234_8001, 1'b1, 0, -1, -1);
        chk("latency", KW'(kv_edge - e0 + 1), KW'(KW + 2));
        chk("load_key", key_out, 64'hA5A5_0F0F_1234_8001);
        chk("load_err", KW'(error), '0);

        // start in LOADED is ignored
        cyc(1, 0, 0, 0);
        chk("start_loaded", key_out, 64'hA5A5_0F0F_1234_8001);
        repeat (3) cyc(0, 0, 1, 1);

        // bad parity then restart from ERROR
        cyc(0, 1, 0, 0);
        chk("clear_zero", key_out, '0);
        cyc(1, 0, 0, 0);
        send_key(64'hA5A5_0F0F_1234_8001, 1'b0, 0, -1, -1);
        chk("bad_err", KW'(error), 64'd1);
        chk("bad_key", key_out, '0);
        chk("bad_valid", KW'(key_valid), '0);
        cyc(1, 0, 0, 0);
        send_key(64'hA5A5_0F0F_1234_8001, 1'b1, 0, -1, -1);
        chk("reload_key", key_out, 64'hA5A5_0F0F_1234_8001);
        chk("reload_err", KW'(error), '0);

        // stalled source
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        send_key(64'h1, 1'b1, 5, -1, -1);
        chk("stall_key", key_out, 64'h1);

        // abort after 20 bits, then a clean load
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        send_key(64'hA5A5_0F0F_1234_8001, 1'b1, 0, -1, 20);
        chk("abort_busy", KW'(busy), '0);
        cyc(1, 0, 0, 0);
        send_key(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0, -1, -1);
        chk("abort_key", key_out, 64'hFFFF_FFFF_FFFF_FFFE);

        // start+clear together from IDLE stays idle
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("stclr_busy", KW'(busy), '0);
        chk("stclr_ready", KW'(bit_ready), '0);

        // start at bit 10 during SHIFT is ignored
        cyc(1, 0, 0, 0);
        send_key(64'h0123_4567_89AB_CDEF, 1'b0, 1, 10, -1);
        chk("midstart_key", key_out, 64'h0123_4567_89AB_CDEF);

        // async reset in LOADED, checked before the next clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_key_out", key_out, '0);
        chk("arst_key_valid", KW'(key_valid), '0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 8) == 0, ($urandom % 150) == 0,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
